// File: rtl/can_arb_pkg.sv
// rtl/can_arb_pkg.sv - shared state encoding and bus constants for can_arbiter_n
package can_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SOF,
    ST_ARB,
    ST_FIN
  } arb_state_e;

  localparam logic DOMINANT  = 1'b0;
  localparam logic RECESSIVE = 1'b1;
  localparam int   STUFF_RUN = 5;

endpackage

// File: rtl/can_bit_timer.sv
// rtl/can_bit_timer.sv - bit-period counter, SAMPLE pulses on the last cycle of each bit
module can_bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  output logic SAMPLE
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Held at zero while disabled so every bit period starts aligned.
  always_comb begin
    cnt_d = '0;
    if (EN && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign SAMPLE = EN && (cnt_q == LAST);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/can_arbiter_n.sv
// rtl/can_arbiter_n.sv - N-node CAN identifier arbitration on a modelled wired-AND bus
// Optional bit stuffing is enabled by defining CAN_ARB_STUFF_EN.
module can_arbiter_n
  import can_arb_pkg::*;
#(
  parameter int N_NODES    = 3,
  parameter int ID_W       = 11,
  parameter int BIT_CYCLES = 4
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             START,
  input  logic [N_NODES-1:0]               REQ,
  input  logic [N_NODES-1:0][ID_W-1:0]     MSG_ID,
  output logic                             CAN_BUS,
  output logic                             BUSY,
  output logic [N_NODES-1:0]               LOST,
  output logic [N_NODES-1:0]               WIN_ONEHOT,
  output logic [$clog2(N_NODES)-1:0]       WIN_IDX,
  output logic [ID_W-1:0]                  WIN_ID,
  output logic                             DONE,
  output logic                             DUP
);

  localparam int IDX_W = $clog2(N_NODES);
  localparam int BIT_W = $clog2(ID_W);

  arb_state_e                   state_q, state_d;
  logic [N_NODES-1:0]           req_q, req_d;
  logic [N_NODES-1:0][ID_W-1:0] id_q, id_d;
  logic [N_NODES-1:0]           lost_q, lost_d;
  logic [N_NODES-1:0]           win_q, win_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [ID_W-1:0]              win_id_q, win_id_d;
  logic                         dup_q, dup_d;
  logic [BIT_W-1:0]             bit_idx_q, bit_idx_d;

  logic sample;
  logic busy;
  logic arb_level;
  logic stuff_act;
  logic stuff_level;

  assign busy = (state_q == ST_SOF) || (state_q == ST_ARB);

  can_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .CLK   (CLK),
    .RST   (RST),
    .EN    (busy),
    .SAMPLE(sample)
  );

  // Wired-AND of every node still in contention for the current ID bit.
  always_comb begin
    arb_level = RECESSIVE;
    for (int n = 0; n < N_NODES; n++) begin
      if (req_q[n] && !lost_q[n] && (id_q[n][bit_idx_q] == DOMINANT)) begin
        arb_level = DOMINANT;
      end
    end
  end

  always_comb begin
    CAN_BUS = RECESSIVE;
    case (state_q)
      ST_SOF:  CAN_BUS = DOMINANT;
      ST_ARB:  CAN_BUS = stuff_act ? stuff_level : arb_level;
      default: CAN_BUS = RECESSIVE;
    endcase
  end

`ifdef CAN_ARB_STUFF_EN
  logic       stuff_q, stuff_d;
  logic       last_q, last_d;
  logic [2:0] run_q, run_d;

  // Run length of identical bus levels since SOF; a stuff bit restarts the run.
  always_comb begin
    stuff_d = stuff_q;
    last_d  = last_q;
    run_d   = run_q;
    if (!busy) begin
      stuff_d = 1'b0;
      last_d  = RECESSIVE;
      run_d   = '0;
    end else if (sample) begin
      if (state_q == ST_SOF) begin
        last_d = DOMINANT;
        run_d  = 3'd1;
      end else if (stuff_q) begin
        stuff_d = 1'b0;
        last_d  = CAN_BUS;
        run_d   = 3'd1;
      end else begin
        run_d  = (CAN_BUS == last_q) ? run_q + 3'd1 : 3'd1;
        last_d = CAN_BUS;
        if ((run_d == 3'(STUFF_RUN)) && (bit_idx_q != '0)) begin
          stuff_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      stuff_q <= 1'b0;
      last_q  <= RECESSIVE;
      run_q   <= '0;
    end else begin
      stuff_q <= stuff_d;
      last_q  <= last_d;
      run_q   <= run_d;
    end
  end

  assign stuff_act   = stuff_q;
  assign stuff_level = ~last_q;
`else
  assign stuff_act   = 1'b0;
  assign stuff_level = RECESSIVE;
`endif

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    id_d      = id_q;
    lost_d    = lost_q;
    win_d     = win_q;
    idx_d     = idx_q;
    win_id_d  = win_id_q;
    dup_d     = dup_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (START && (REQ != '0)) begin
          state_d  = ST_SOF;
          req_d    = REQ;
          id_d     = MSG_ID;
          lost_d   = '0;
          win_d    = '0;
          idx_d    = '0;
          win_id_d = '0;
          dup_d    = 1'b0;
        end
      end
      ST_SOF: begin
        if (sample) begin
          state_d   = ST_ARB;
          bit_idx_d = BIT_W'(ID_W - 1);
        end
      end
      ST_ARB: begin
        if (sample && !stuff_act) begin
          for (int n = 0; n < N_NODES; n++) begin
            if (req_q[n] && !lost_q[n] && (id_q[n][bit_idx_q] == RECESSIVE) &&
                (CAN_BUS == DOMINANT)) begin
              lost_d[n] = 1'b1;
            end
          end
          if (bit_idx_q == '0) begin
            state_d = ST_FIN;
            win_d   = req_q & ~lost_d;
            dup_d   = ($countones(win_d) > 1);
            // Descending scan leaves the lowest surviving index.
            for (int n = N_NODES - 1; n >= 0; n--) begin
              if (win_d[n]) begin
                idx_d    = IDX_W'(n);
                win_id_d = id_q[n];
              end
            end
          end else begin
            bit_idx_d = bit_idx_q - 1'b1;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      id_q      <= '0;
      lost_q    <= '0;
      win_q     <= '0;
      idx_q     <= '0;
      win_id_q  <= '0;
      dup_q     <= 1'b0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      id_q      <= id_d;
      lost_q    <= lost_d;
      win_q     <= win_d;
      idx_q     <= idx_d;
      win_id_q  <= win_id_d;
      dup_q     <= dup_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  assign BUSY       = busy;
  assign DONE       = (state_q == ST_FIN);
  assign LOST       = lost_q;
  assign WIN_ONEHOT = win_q;
  assign WIN_IDX    = idx_q;
  assign WIN_ID     = win_id_q;
  assign DUP        = dup_q;

endmodule

// File: tb/tb_can_arbiter_n.sv
// tb/tb_can_arbiter_n.sv - self-checking bench for can_arbiter_n against a bus-level reference model
module tb_can_arbiter_n;

  localparam int N = 3;
  localparam int W = 11;
  localparam int B = 4;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic                  START;
  logic [N-1:0]          REQ;
  logic [N-1:0][W-1:0]   MSG_ID;
  logic                  CAN_BUS;
  logic                  BUSY;
  logic [N-1:0]          LOST;
  logic [N-1:0]          WIN_ONEHOT;
  logic [$clog2(N)-1:0]  WIN_IDX;
  logic [W-1:0]          WIN_ID;
  logic                  DONE;
  logic                  DUP;

  int checks = 0;
  int errors = 0;

  can_arbiter_n #(.N_NODES(N), .ID_W(W), .BIT_CYCLES(B)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .REQ       (REQ),
    .MSG_ID    (MSG_ID),
    .CAN_BUS   (CAN_BUS),
    .BUSY      (BUSY),
    .LOST      (LOST),
    .WIN_ONEHOT(WIN_ONEHOT),
    .WIN_IDX   (WIN_IDX),
    .WIN_ID    (WIN_ID),
    .DONE      (DONE),
    .DUP       (DUP)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  // Reference model: the bus carries SOF then the smallest competing ID.
  logic         seq[$];
  int           pos_lost[N];
  logic [N-1:0] m_win, m_lost;
  int           m_idx;
  logic [W-1:0] m_id;
  logic         m_dup;
  logic [N-1:0] h_win, h_lost;
  int           h_idx;
  logic [W-1:0] h_id;
  logic         h_dup;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_model(input logic [N-1:0] req, input logic [N-1:0][W-1:0] ids);
    logic [W-1:0] minid;
    logic         last;
    int           run;
    int           pos[W];
    minid = '1;
    for (int n = 0; n < N; n++) if (req[n] && ids[n] < minid) minid = ids[n];
    seq.delete();
    seq.push_back(1'b0);
    last = 1'b0;
    run  = 1;
    for (int i = W - 1; i >= 0; i--) begin
      pos[i] = seq.size();
      seq.push_back(minid[i]);
      if (minid[i] == last) run++;
      else begin
        last = minid[i];
        run  = 1;
      end
`ifdef CAN_ARB_STUFF_EN
      if (run == 5 && i != 0) begin
        seq.push_back(~last);
        last = ~last;
        run  = 1;
      end
`endif
    end
    m_win  = '0;
    m_lost = '0;
    m_idx  = -1;
    m_id   = '0;
    for (int n = 0; n < N; n++) begin
      pos_lost[n] = -1;
      if (req[n]) begin
        if (ids[n] == minid) begin
          m_win[n] = 1'b1;
          if (m_idx < 0) begin
            m_idx = n;
            m_id  = ids[n];
          end
        end else begin
          m_lost[n] = 1'b1;
          for (int i = W - 1; i >= 0; i--)
            if (pos_lost[n] < 0 && ids[n][i] != minid[i]) pos_lost[n] = pos[i];
        end
      end
    end
    m_dup = ($countones(m_win) > 1);
  endtask

  task automatic check_idle_hold(input string tag);
    check({tag, "_busy"}, 32'(BUSY), 32'(1'b0));
    check({tag, "_done"}, 32'(DONE), 32'(1'b0));
    check({tag, "_bus"}, 32'(CAN_BUS), 32'(1'b1));
    check({tag, "_lost"}, 32'(LOST), 32'(h_lost));
    check({tag, "_win"}, 32'(WIN_ONEHOT), 32'(h_win));
    check({tag, "_idx"}, 32'(WIN_IDX), 32'(h_idx));
    check({tag, "_id"}, 32'(WIN_ID), 32'(h_id));
    check({tag, "_dup"}, 32'(DUP), 32'(h_dup));
  endtask

  task automatic run_arb(input logic [N-1:0] req, input logic [N-1:0][W-1:0] ids, input int inject_t);
    int           nb;
    int           done_t;
    logic         e_bus;
    logic [N-1:0] e_lost;
    build_model(req, ids);
    nb     = seq.size() * B;
    done_t = nb + 1;
    @(negedge CLK);
    START  = 1'b1;
    REQ    = req;
    MSG_ID = ids;
    for (int t = 1; t <= done_t + 1; t++) begin
      @(negedge CLK);
      START = (t == inject_t);
      REQ   = N'($urandom_range(1, (1 << N) - 1));
      for (int n = 0; n < N; n++) MSG_ID[n] = W'($urandom);
      e_bus = (t <= nb) ? seq[(t - 1) / B] : 1'b1;
      for (int n = 0; n < N; n++)
        e_lost[n] = (pos_lost[n] >= 0) && (t >= (pos_lost[n] + 1) * B + 1);
      check("busy", 32'(BUSY), 32'(t <= nb));
      check("done", 32'(DONE), 32'(t == done_t));
      check("can_bus", 32'(CAN_BUS), 32'(e_bus));
      check("lost", 32'(LOST), 32'(e_lost));
      check("win_onehot", 32'(WIN_ONEHOT), (t >= done_t) ? 32'(m_win) : 32'd0);
      check("win_idx", 32'(WIN_IDX), (t >= done_t) ? 32'(m_idx) : 32'd0);
      check("win_id", 32'(WIN_ID), (t >= done_t) ? 32'(m_id) : 32'd0);
      check("dup", 32'(DUP), (t >= done_t) ? 32'(m_dup) : 32'd0);
    end
    START  = 1'b0;
    h_win  = m_win;
    h_lost = m_lost;
    h_idx  = m_idx;
    h_id   = m_id;
    h_dup  = m_dup;
  endtask

  initial begin
    logic [N-1:0][W-1:0] ids;
    logic [N-1:0]        rq;
    logic [W-1:0]        base;

    RST    = 1'b0;
    START  = 1'b0;
    REQ    = '0;
    MSG_ID = '0;
    h_win  = '0;
    h_lost = '0;
    h_idx  = 0;
    h_id   = '0;
    h_dup  = 1'b0;
    repeat (3) @(negedge CLK);
    check_idle_hold("reset");
    RST = 1'b1;

    ids = {11'h6A4, 11'h6A5, 11'h7B3};
    run_arb(3'b111, ids, 0);

    ids = {11'h123, 11'h456, 11'h7FF};
    run_arb(3'b001, ids, 0);

    ids = {11'h6A4, 11'h6A4, 11'h001};
    run_arb(3'b110, ids, 0);

    ids = {11'h6A4, 11'h6A5, 11'h7B3};
    run_arb(3'b111, ids, 10);

    @(negedge CLK);
    START = 1'b1;
    REQ   = '0;
    for (int t = 0; t < 6; t++) begin
      @(negedge CLK);
      START = 1'b0;
      check_idle_hold("req0");
    end

    @(negedge CLK);
    START  = 1'b1;
    REQ    = 3'b111;
    MSG_ID = {11'h6A4, 11'h6A5, 11'h7B3};
    for (int t = 1; t <= 29; t++) begin
      @(negedge CLK);
      START = 1'b0;
      if (t <= 20) check("pre_reset_busy", 32'(BUSY), 32'(1'b1));
      if (t == 20) RST = 1'b0;
      if (t == 21) begin
        RST = 1'b1;
        check("abort_lost", 32'(LOST), 32'd0);
      end
      if (t >= 21) begin
        check("abort_busy", 32'(BUSY), 32'(1'b0));
        check("abort_done", 32'(DONE), 32'(1'b0));
        check("abort_bus", 32'(CAN_BUS), 32'(1'b1));
        check("abort_win", 32'(WIN_ONEHOT), 32'd0);
      end
    end
    ids = {11'h6A4, 11'h6A5, 11'h7B3};
    run_arb(3'b111, ids, 0);

    ids = {11'h3C3, 11'h2AA, 11'h000};
    run_arb(3'b001, ids, 0);

    for (int k = 0; k < 25; k++) begin
      base = W'($urandom);
      rq   = N'($urandom_range(1, (1 << N) - 1));
      for (int n = 0; n < N; n++) begin
        case ($urandom_range(0, 3))
          0:       ids[n] = W'($urandom);
          1:       ids[n] = ids[0];
          default: ids[n] = base ^ W'($urandom_range(0, 63));
        endcase
      end
      run_arb(rq, ids, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 40)) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/can_arbiter_n.md
CAN_ARBITER_N -- requirements
Module: can_arbiter_n

Interface
REQ-001 Parameter N_NODES, default 3: number of contending nodes, 2..16.
REQ-002 Parameter ID_W, default 11: message ID width, 11..29.
REQ-003 Parameter BIT_CYCLES, default 4: clock cycles per bus bit, 2..64.
REQ-004 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-005 RST  input  1  reset, synchronous, active-low.
REQ-006 START  input  1  one-cycle request to begin arbitration.
REQ-007 REQ  input  N_NODES  per-node participation mask.
REQ-008 MSG_ID  input  N_NODES x ID_W  per-node message ID, MSB sent first.
REQ-009 CAN_BUS  output  1  wired-AND bus level: 0 = dominant, 1 = recessive.
REQ-010 BUSY  output  1  arbitration in progress.
REQ-011 LOST  output  N_NODES  sticky per-node lost flags.
REQ-012 WIN_ONEHOT  output  N_NODES  surviving nodes.
REQ-013 WIN_IDX  output  $clog2(N_NODES)  lowest surviving index.
REQ-014 WIN_ID  output  ID_W  winning ID.
REQ-015 DONE  output  1  one-cycle completion pulse.
REQ-016 DUP  output  1  more than one survivor, meaning identical IDs.

Function
REQ-017 FSM states: IDLE, SOF, ARB, FIN.
- IDLE -> SOF on START with BUSY=0 and REQ!=0.
- SOF -> ARB after one bit period.
- ARB -> FIN after the bit-0 sample.
- FIN -> IDLE after one cycle.
REQ-018 REQ and MSG_ID are latched on the accepting START edge; later input changes have no effect until the next accepted START.
REQ-019 A START seen while BUSY=1, or with REQ=0, is ignored: no state change, no flag change.
REQ-020 SOF bit: CAN_BUS=0. ARB bit i: CAN_BUS = AND over latched-REQ nodes with LOST=0 of MSG_ID[n][i]. Non-participating nodes drive 1.
REQ-021 Sample point is the last cycle of each bit period. A participating node that drives 1 while CAN_BUS=0 sets LOST[n] on that edge.
REQ-022 Latency, no stuffing: START accepted at edge k; SOF occupies cycles k+1..k+BIT_CYCLES; DONE=1 in cycle k+1+(1+ID_W)*BIT_CYCLES.
REQ-023 Behaviour in FIN:
- WIN_ONEHOT = latched REQ & ~LOST.
- WIN_IDX = lowest set bit of WIN_ONEHOT.
- WIN_ID = that node's ID.
- DUP = popcount(WIN_ONEHOT)>1.
- These outputs are held until the next accepted START clears them. LOST is also cleared on that START.
REQ-024 BUSY=1 in SOF and ARB only. CAN_BUS=1 in IDLE and FIN.

Reset
REQ-025 While RST=0 at a posedge, the next-cycle values are:
- FSM=IDLE, CAN_BUS=1.
- BUSY, DONE, DUP = 0.
- LOST, WIN_ONEHOT, WIN_IDX, WIN_ID = 0.
- Bit-timer and stuff counters = 0.
REQ-026 A reset during SOF or ARB aborts the arbitration. No DONE is produced, and the next START after reset release begins a fresh arbitration.

Configuration
REQ-027 Macro CAN_ARB_STUFF_EN, defined: after 5 consecutive identical bus bits, counting from SOF, the block inserts one complementary stuff bit period.
- The stuff bit counts as bit 1 of the next run.
- No node can lose on a stuff bit.
- No stuff bit is inserted after ID bit 0.
- DONE is delayed by BIT_CYCLES per inserted stuff bit.
REQ-028 Macro CAN_ARB_STUFF_EN, undefined: there is no stuff logic, and the REQ-022 latency is exact.

Structure
REQ-029 Package can_arb_pkg holds:
- the FSM state enum;
- constants DOMINANT=1'b0 and RECESSIVE=1'b1;
- the stuff run length constant 5.
REQ-030 Sub-module can_bit_timer(CLK, RST, EN, SAMPLE) counts 0..BIT_CYCLES-1 and pulses SAMPLE on the last count. can_arbiter_n instantiates it once.

Verification
REQ-031 Three-node arbitration, defaults, no stuffing: ID0=7B3, ID1=6A5, ID2=6A4, REQ=111, START at cycle 0.
- LOST[0] sets at the bit-8 sample.
- LOST[1] sets at the bit-0 sample.
- DONE at cycle 49, with WIN_IDX=2, WIN_ID=6A4, LOST=011, DUP=0.
REQ-032 Single node: REQ=001, ID0=7FF -> DONE at cycle 49, WIN_IDX=0, LOST=000.
REQ-033 Duplicate IDs: ID1=ID2=6A4, REQ=110 -> WIN_ONEHOT=110, WIN_IDX=1, DUP=1.
REQ-034 Reset at cycle 20 of an arbitration -> cycle 21 shows BUSY=0, CAN_BUS=1 and LOST=0. No DONE is produced, and a new START at cycle 30 gives DONE at cycle 79.
REQ-035 Ignored starts:
- START while BUSY=1 -> no effect.
- START with REQ=000 -> BUSY stays 0.
REQ-036 Stuffing, CAN_ARB_STUFF_EN defined: single node, ID0=000.
- Stuff 1s follow SOF+b10..b7 and b6..b2.
- 14 bit periods in total; DONE at cycle 57.
